// File: rtl/sc_spi_target.sv
// SPI target engine: oversamples CSB/SCLK/MOSI in SYSCLK, deserialises MOSI and serialises MISO.
// Optional RX handshake/overrun tracking: define SC_SPI_TARGET_OVERRUN_EN.
module sc_spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RST_TXDATA  = 32'h0
) (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic [4:0]  DWIDTH,
  input  logic [31:0] TXDATA,
  input  logic        TXVALID,
  output logic        TXREADY,
  output logic        TXUNDERRUN,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
`ifdef SC_SPI_TARGET_OVERRUN_EN
  input  logic        RXREADY,
  output logic        RXOVERRUN,
`endif
  output logic        BUSY,
  output logic        ABORT,
  input  logic        CSB,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q;
  logic csb_hist_q, sclk_hist_q;
  logic csb_s, sclk_s, mosi_s;
  logic csb_fall, csb_rise, sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

  state_e      state_q, state_d;
  logic        cpol_q, cpol_d, cpha_q, cpha_d, border_q, border_d;
  logic [4:0]  dw_q, dw_d, bitcnt_q, bitcnt_d;
  logic [30:0] rxsr_q, rxsr_d;
  logic [31:0] txsr_q, txsr_d, rxdata_q, rxdata_d;
  logic        fresh_q, fresh_d, miso_q, miso_d, rxvalid_q, rxvalid_d;
  logic        txready_q, txready_d, txund_q, txund_d, abort_q, abort_d;
  logic        load_tx, rx_done;
  logic [31:0] tx_word, tx_shifted, rx_shift, rx_just;
`ifdef SC_SPI_TARGET_OVERRUN_EN
  logic        rxovr_q, rxovr_d;
`endif

  // MSB-first words are pre-aligned so the active bit is always at bit 31.
  function automatic logic [31:0] tx_align(input logic [31:0] w, input logic [4:0] dw,
                                           input logic lsb_first);
    return lsb_first ? w : (w << (5'd31 - dw));
  endfunction

  function automatic logic tx_head(input logic [31:0] sr, input logic lsb_first);
    return lsb_first ? sr[0] : sr[31];
  endfunction

  function automatic logic [31:0] rx_justify(input logic [31:0] raw, input logic [4:0] dw,
                                             input logic lsb_first);
    logic [31:0] rev;
    for (int unsigned i = 0; i < 32; i++) rev[i] = raw[31-i];
    if (lsb_first) return rev >> (5'd31 - dw);
    return raw & (32'hFFFF_FFFF >> (5'd31 - dw));
  endfunction

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      csb_sync_q  <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csb_hist_q  <= 1'b0;
      sclk_hist_q <= 1'b0;
    end else begin
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], CSB};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      csb_hist_q  <= csb_s;
      sclk_hist_q <= sclk_s;
    end
  end

  assign csb_s       = csb_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign csb_fall    = csb_hist_q & ~csb_s;
  assign csb_rise    = ~csb_hist_q & csb_s;
  assign sclk_edge   = sclk_hist_q ^ sclk_s;
  assign lead_edge   = sclk_edge & (sclk_hist_q == cpol_q);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign tx_word    = TXVALID ? TXDATA : RST_TXDATA;
  assign tx_shifted = border_q ? (txsr_q >> 1) : (txsr_q << 1);
  assign rx_shift   = {rxsr_q, mosi_s};
  assign rx_just    = rx_justify(rx_shift, dw_q, border_q);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    border_d  = border_q;
    dw_d      = dw_q;
    bitcnt_d  = bitcnt_q;
    rxsr_d    = rxsr_q;
    txsr_d    = txsr_q;
    fresh_d   = fresh_q;
    miso_d    = miso_q;
    rxdata_d  = rxdata_q;
    txready_d = 1'b0;
    txund_d   = 1'b0;
    abort_d   = 1'b0;
    load_tx   = 1'b0;
    rx_done   = 1'b0;
    case (state_q)
      WAIT_IDLE: if (csb_s) state_d = IDLE;
      IDLE: begin
        if (csb_fall) begin
          state_d  = ACTIVE;
          cpol_d   = CPOL;
          cpha_d   = CPHA;
          border_d = BORDER;
          dw_d     = DWIDTH;
          bitcnt_d = '0;
          load_tx  = 1'b1;
          txsr_d   = tx_align(tx_word, DWIDTH, BORDER);
          miso_d   = tx_head(tx_align(tx_word, DWIDTH, BORDER), BORDER);
          // With CPHA=1 the first leading edge re-presents this bit instead of shifting.
          fresh_d  = CPHA;
        end
      end
      ACTIVE: begin
        if (csb_rise) begin
          state_d = IDLE;
          abort_d = (bitcnt_q != '0);
        end else begin
          if (sample_edge) begin
            rxsr_d = rx_shift[30:0];
            if (bitcnt_q == dw_q) begin
              rx_done  = 1'b1;
              bitcnt_d = '0;
              load_tx  = 1'b1;
              txsr_d   = tx_align(tx_word, dw_q, border_q);
              fresh_d  = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
          if (shift_edge) begin
            if (fresh_q) begin
              miso_d  = tx_head(txsr_q, border_q);
              fresh_d = 1'b0;
            end else begin
              txsr_d = tx_shifted;
              miso_d = tx_head(tx_shifted, border_q);
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (load_tx) begin
      txready_d = TXVALID;
      txund_d   = ~TXVALID;
    end
`ifdef SC_SPI_TARGET_OVERRUN_EN
    rxvalid_d = rxvalid_q & ~RXREADY;
    rxovr_d   = rxovr_q;
    if (RXREADY && !rxvalid_q) rxovr_d = 1'b0;
    if (rx_done) begin
      if (rxvalid_q && !RXREADY) begin
        rxovr_d = 1'b1;
      end else begin
        rxdata_d  = rx_just;
        rxvalid_d = 1'b1;
      end
    end
`else
    rxvalid_d = rx_done;
    if (rx_done) rxdata_d = rx_just;
`endif
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q   <= WAIT_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      border_q  <= 1'b0;
      dw_q      <= '0;
      bitcnt_q  <= '0;
      rxsr_q    <= '0;
      txsr_q    <= '0;
      fresh_q   <= 1'b0;
      miso_q    <= 1'b0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      txready_q <= 1'b0;
      txund_q   <= 1'b0;
      abort_q   <= 1'b0;
`ifdef SC_SPI_TARGET_OVERRUN_EN
      rxovr_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      border_q  <= border_d;
      dw_q      <= dw_d;
      bitcnt_q  <= bitcnt_d;
      rxsr_q    <= rxsr_d;
      txsr_q    <= txsr_d;
      fresh_q   <= fresh_d;
      miso_q    <= miso_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      txready_q <= txready_d;
      txund_q   <= txund_d;
      abort_q   <= abort_d;
`ifdef SC_SPI_TARGET_OVERRUN_EN
      rxovr_q   <= rxovr_d;
`endif
    end
  end

  assign TXREADY    = txready_q;
  assign TXUNDERRUN = txund_q;
  assign RXDATA     = rxdata_q;
  assign RXVALID    = rxvalid_q;
  assign ABORT      = abort_q;
  assign BUSY       = (state_q == ACTIVE);
  assign MISO_OE    = (state_q == ACTIVE);
  assign MISO       = miso_q;
`ifdef SC_SPI_TARGET_OVERRUN_EN
  assign RXOVERRUN  = rxovr_q;
`endif

endmodule
